encode_pack: RTL and testbench
==============================

Name: encode_pack

Overview:
- LZS bitstream packer: the transmit-side counterpart of decode_ctl.
- Accepts tokens from the match engine: literal, match (offset, length) or end.
- Emits the matching variable-width LZS codes, MSB-first, as a byte stream into the output FIFO.
- Pads the final byte with zeros and flags completion on all_end.

Parameters:
- ACC_W, 24, bit-accumulator width; must be at least 13 + 11.
- LEN_W, 12, width of the match-length input.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ce_encode  in  1  start/enable encoding of one stream
- tok_valid  in  1  token present
- tok_ready  out  1  token accepted this cycle when tok_valid & tok_ready
- tok_type  in  2  0 literal, 1 match, 2 end, 3 reserved (ignored, accepted, no bits)
- tok_lit  in  8  literal byte
- tok_off  in  11  match offset, 1..2047
- tok_len  in  LEN_W  match length, 2..4095
- fo_full  in  1  output FIFO full; no byte is drained while high
- out_data  out  8  packed byte
- out_valid  out  1  out_data valid, one-cycle write strobe
- all_end  out  1  stream fully flushed

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values:
  - state = S_IDLE; accumulator and bit count cleared.
  - out_data = 0, out_valid = 0, tok_ready = 0, all_end = 0.
  - Reset mid-stream discards all buffered bits; nothing is emitted after it.
- Codes, MSB-first:
  - literal = 0 + lit[7:0] (9 bits).
  - match with off < 128 = 11 + off[6:0] (9 bits).
  - match with off >= 128 = 10 + off[10:0] (13 bits).
  - end = 110000000 (9 bits).
  - length 2/3/4 = 00/01/10.
  - length 5/6/7 = 1100/1101/1110.
  - length >= 8 = 1111, then the extension r = len-8 in nibbles: 1111 while r >= 15 (r -= 15), then the final nibble r (0..14).
- Accumulator:
  - Left-aligned, with a bit count bcnt (0..ACC_W).
  - At most one code is appended per cycle (width W <= 13), and only when bcnt <= ACC_W-13.
  - At most one byte is drained per cycle: if bcnt >= 8 and !fo_full, the top 8 bits go to out_data and out_valid = 1 on the next cycle.
  - Append and drain on the same edge is legal: bcnt_next = bcnt + W - 8.
  - Bits are never dropped or reordered under backpressure.
- States:
  - S_IDLE: tok_ready = 0. Go to S_TOKEN when ce_encode = 1.
  - S_TOKEN: tok_ready = (bcnt <= ACC_W-13).
    - On accept of a literal, append 9 bits; stay.
    - On accept of a match, append the offset code, latch len into len_r, go to S_LEN.
    - On accept of end, append the end code, go to S_FLUSH.
  - S_LEN: when there is room, append the 2- or 4-bit length code.
    - If len_r >= 8, set len_r = len_r-8 and go to S_EXT.
    - Otherwise return to S_TOKEN.
  - S_EXT: when there is room, append one nibble per cycle: 1111 with len_r -= 15 while len_r >= 15; else nibble len_r, then go to S_TOKEN.
  - S_FLUSH: drain full bytes.
    - If 0 < bcnt < 8 and !fo_full, emit the remaining bits left-aligned with zeros in the low bits; bcnt = 0.
    - When bcnt == 0, go to S_END.
  - S_END: all_end = 1 (level). Return to S_IDLE once ce_encode = 0, which clears all_end.
- tok_len < 2 is a protocol violation and is encoded as length 2.
- tok_ready is combinational from state and bcnt.
- ce_encode dropping mid-stream has no effect until S_END.
- Latency: a literal accepted at edge k is drained at edge k+1 (bcnt = 9) if fo_full = 0, so out_valid is high in the cycle after edge k+1.

Decomposition:
- Shared package (lzs_pkg):
  - tok_type encodings: TOK_LIT, TOK_MATCH, TOK_END.
  - END_CODE 9'b110000000.
  - The short-offset threshold 128.
- One natural sub-module: bit_packer (accumulator with append width/data and the byte drain/flush).
- encode_pack keeps the FSM and the code generation.

Test Plan:
- Literal 0x41, then end, fo_full = 0 -> bytes 0x20, 0xE0, 0x00 (pad); then all_end = 1.
- Match off = 5 len = 2, then end -> 0xC2, 0x98, 0x00; all_end = 1.
- Match off = 300 len = 8, then end -> 0x89, 0x67, 0x86, 0x00.
- Match off = 1 len = 23 -> length field 1111 1111 0000; len = 22 -> 1111 1110. Decode through decode_ctl and compare.
- fo_full held high for 20 cycles during a stream of 4 literals ->
  - no out_valid while fo_full is high;
  - tok_ready drops once bcnt > 11;
  - after release, the byte sequence is identical to the run without backpressure.
- Assert rst during S_EXT -> next cycle all outputs are 0 and state is S_IDLE; a new stream (literal 0x41 + end) yields exactly 0x20, 0xE0, 0x00.

Source files
------------

// File: rtl/lzs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lzs_pkg
//  Description : Shared token encodings, FSM states and code constants for
//                the LZS bitstream packer.
//  Revision    : 1.0  initial release
// ============================================================================
package lzs_pkg;

  typedef enum logic [1:0] {
    TOK_LIT   = 2'd0,
    TOK_MATCH = 2'd1,
    TOK_END   = 2'd2,
    TOK_RSVD  = 2'd3
  } tok_type_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TOKEN = 3'd1,
    S_LEN   = 3'd2,
    S_EXT   = 3'd3,
    S_FLUSH = 3'd4,
    S_END   = 3'd5
  } enc_state_e;

  localparam logic [8:0]  END_CODE        = 9'b110000000;
  localparam int unsigned SHORT_OFF_LIMIT = 128;
  localparam int unsigned MAX_CODE_W      = 13;

endpackage
`default_nettype wire

// File: rtl/encode_pack_bit_packer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_packer
//  Description : Left-aligned bit accumulator; appends one right-aligned code
//                per cycle and drains one byte per cycle, with final padding.
//  Revision    : 1.0  initial release
// ============================================================================
module bit_packer #(
  parameter int ACC_W  = 24,
  parameter int BCNT_W = $clog2(ACC_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_app_en,
  input  logic [3:0]        i_app_w,
  input  logic [12:0]       i_app_data,
  input  logic              i_flush,
  input  logic              i_fo_full,
  output logic [BCNT_W-1:0] o_bcnt,
  output logic [7:0]        o_out_data,
  output logic              o_out_valid
);

  logic [ACC_W-1:0]  r_acc;
  logic [BCNT_W-1:0] r_bcnt;
  logic              w_drain;
  logic              w_pad;
  logic [ACC_W-1:0]  w_acc_d;
  logic [BCNT_W-1:0] w_bcnt_d;
  logic [BCNT_W-1:0] w_shift;
  logic [ACC_W-1:0]  w_ins;
  logic [ACC_W-1:0]  w_acc_n;
  logic [BCNT_W-1:0] w_bcnt_n;

  always_comb begin
    w_drain  = (r_bcnt >= BCNT_W'(8)) && !i_fo_full;
    w_pad    = i_flush && (r_bcnt != '0) && (r_bcnt < BCNT_W'(8)) && !i_fo_full;
    w_acc_d  = r_acc;
    w_bcnt_d = r_bcnt;
    if (w_drain) begin
      w_acc_d  = r_acc << 8;
      w_bcnt_d = r_bcnt - BCNT_W'(8);
    end else if (w_pad) begin
      w_acc_d  = '0;
      w_bcnt_d = '0;
    end
    // The new code lands directly below the bits that survive the drain.
    w_shift  = BCNT_W'(ACC_W) - w_bcnt_d - BCNT_W'(i_app_w);
    w_ins    = {{(ACC_W-13){1'b0}}, i_app_data} << w_shift;
    w_acc_n  = i_app_en ? (w_acc_d | w_ins) : w_acc_d;
    w_bcnt_n = i_app_en ? (w_bcnt_d + BCNT_W'(i_app_w)) : w_bcnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_bcnt      <= '0;
      o_out_data  <= '0;
      o_out_valid <= 1'b0;
    end else begin
      r_acc       <= w_acc_n;
      r_bcnt      <= w_bcnt_n;
      o_out_valid <= w_drain || w_pad;
      if (w_drain || w_pad)
        o_out_data <= r_acc[ACC_W-1 -: 8];
    end
  end

  assign o_bcnt = r_bcnt;

endmodule
`default_nettype wire

// File: rtl/encode_pack.sv
`default_nettype none
// ============================================================================
//  Module      : encode_pack
//  Description : LZS token encoder; turns literal/match/end tokens into
//                MSB-first variable-width codes packed into bytes.
//  Revision    : 1.0  initial release
// ============================================================================
module encode_pack
  import lzs_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_encode,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic [1:0]       tok_type,
  input  logic [7:0]       tok_lit,
  input  logic [10:0]      tok_off,
  input  logic [LEN_W-1:0] tok_len,
  input  logic             fo_full,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             all_end
);

  localparam int BCNT_W = $clog2(ACC_W + 1);

  enc_state_e        r_state;
  logic [LEN_W-1:0]  r_len;
  logic              r_all_end;
  logic [BCNT_W-1:0] w_bcnt;
  logic              w_room;
  logic              w_accept;
  logic              w_app_en;
  logic [3:0]        w_app_w;
  logic [12:0]       w_app_data;
  logic [1:0]        w_len2;
  logic [1:0]        w_len5;

  assign w_room    = w_bcnt <= BCNT_W'(ACC_W - MAX_CODE_W);
  assign tok_ready = (r_state == S_TOKEN) && w_room;
  assign w_accept  = tok_valid && tok_ready;
  assign w_len2    = r_len[1:0] - 2'd2;
  assign w_len5    = r_len[1:0] - 2'd1;
  assign all_end   = r_all_end;

  always_comb begin
    w_app_en   = 1'b0;
    w_app_w    = 4'd0;
    w_app_data = 13'd0;
    case (r_state)
      S_TOKEN: begin
        if (w_accept) begin
          case (tok_type_e'(tok_type))
            TOK_LIT: begin
              w_app_en   = 1'b1;
              w_app_w    = 4'd9;
              w_app_data = {4'b0000, 1'b0, tok_lit};
            end
            TOK_MATCH: begin
              w_app_en = 1'b1;
              if (tok_off < 11'(SHORT_OFF_LIMIT)) begin
                w_app_w    = 4'd9;
                w_app_data = {4'b0000, 2'b11, tok_off[6:0]};
              end else begin
                w_app_w    = 4'd13;
                w_app_data = {2'b10, tok_off};
              end
            end
            TOK_END: begin
              w_app_en   = 1'b1;
              w_app_w    = 4'd9;
              w_app_data = {4'b0000, END_CODE};
            end
            default: ;
          endcase
        end
      end
      S_LEN: begin
        if (w_room) begin
          w_app_en = 1'b1;
          if (r_len <= LEN_W'(4)) begin
            w_app_w    = 4'd2;
            w_app_data = {11'd0, w_len2};
          end else if (r_len <= LEN_W'(7)) begin
            w_app_w    = 4'd4;
            w_app_data = {9'd0, 2'b11, w_len5};
          end else begin
            w_app_w    = 4'd4;
            w_app_data = {9'd0, 4'hF};
          end
        end
      end
      S_EXT: begin
        if (w_room) begin
          w_app_en   = 1'b1;
          w_app_w    = 4'd4;
          w_app_data = (r_len >= LEN_W'(15)) ? {9'd0, 4'hF} : {9'd0, r_len[3:0]};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_all_end <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (ce_encode) r_state <= S_TOKEN;
        S_TOKEN: begin
          if (w_accept) begin
            if (tok_type_e'(tok_type) == TOK_MATCH) begin
              // Lengths below 2 are illegal; clamp so the code stays decodable.
              r_len   <= (tok_len < LEN_W'(2)) ? LEN_W'(2) : tok_len;
              r_state <= S_LEN;
            end else if (tok_type_e'(tok_type) == TOK_END) begin
              r_state <= S_FLUSH;
            end
          end
        end
        S_LEN: begin
          if (w_room) begin
            if (r_len >= LEN_W'(8)) begin
              r_len   <= r_len - LEN_W'(8);
              r_state <= S_EXT;
            end else begin
              r_state <= S_TOKEN;
            end
          end
        end
        S_EXT: begin
          if (w_room) begin
            if (r_len >= LEN_W'(15)) r_len <= r_len - LEN_W'(15);
            else                     r_state <= S_TOKEN;
          end
        end
        S_FLUSH: begin
          if (w_bcnt == '0) begin
            r_state   <= S_END;
            r_all_end <= 1'b1;
          end
        end
        S_END: begin
          if (!ce_encode) begin
            r_state   <= S_IDLE;
            r_all_end <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  bit_packer #(
    .ACC_W  (ACC_W),
    .BCNT_W (BCNT_W)
  ) u_bit_packer (
    .clk         (clk),
    .rst         (rst),
    .i_app_en    (w_app_en),
    .i_app_w     (w_app_w),
    .i_app_data  (w_app_data),
    .i_flush     (r_state == S_FLUSH),
    .i_fo_full   (fo_full),
    .o_bcnt      (w_bcnt),
    .o_out_data  (out_data),
    .o_out_valid (out_valid)
  );

endmodule
`default_nettype wire

// File: tb/tb_encode_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encode_pack
//  Description : Directed self-checking bench for encode_pack.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_encode_pack;
  import lzs_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_encode = 1'b0;
  logic        tok_valid = 1'b0;
  logic        tok_ready;
  logic [1:0]  tok_type = 2'd0;
  logic [7:0]  tok_lit = 8'd0;
  logic [10:0] tok_off = 11'd0;
  logic [11:0] tok_len = 12'd0;
  logic        fo_full = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        all_end;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [7:0] got_q[$];

  encode_pack #(.ACC_W(24), .LEN_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce_encode (ce_encode),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_type  (tok_type),
    .tok_lit   (tok_lit),
    .tok_off   (tok_off),
    .tok_len   (tok_len),
    .fo_full   (fo_full),
    .out_data  (out_data),
    .out_valid (out_valid),
    .all_end   (all_end)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && out_valid) got_q.push_back(out_data);

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_stream();
    @(negedge clk);
    got_q.delete();
    ce_encode = 1'b1;
  endtask

  task automatic send_tok(input logic [1:0] t, input logic [7:0] lit,
                          input logic [10:0] off, input logic [11:0] len);
    int n;
    @(negedge clk);
    tok_type = t; tok_lit = lit; tok_off = off; tok_len = len;
    tok_valid = 1'b1;
    n = 0;
    while (!tok_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tok_accept_wait", 32'(n < 200), 32'd1);
    @(negedge clk);
    tok_valid = 1'b0;
  endtask

  task automatic finish_stream(input string tag, input int nexp, input logic [47:0] bytes);
    int n;
    n = 0;
    while (!all_end && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_all_end"}, 32'(all_end), 32'd1);
    check({tag, "_nbytes"}, 32'(got_q.size()), 32'(nexp));
    for (int i = 0; i < nexp; i++)
      check($sformatf("%s_byte%0d", tag, i),
            (i < got_q.size()) ? 32'(got_q[i]) : 32'hxxxx_xxxx,
            32'(bytes[8*(nexp-1-i) +: 8]));
    ce_encode = 1'b0;
    @(negedge clk);
    check({tag, "_all_end_clr"}, 32'(all_end), 32'd0);
  endtask

  initial begin
    #1;
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_tok_ready", 32'(tok_ready), 32'd0);
    check("rst_all_end",   32'(all_end),   32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Literal 0x41 + end, including first-byte latency
    start_stream();
    send_tok(TOK_LIT, 8'h41, 11'd0, 12'd0);
    check("lit_lat_k", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lit_lat_valid", 32'(out_valid), 32'd1);
    check("lit_lat_data",  32'(out_data),  32'h20);
    send_tok(TOK_END, 8'h00, 11'd0, 12'd0);
    finish_stream("lit", 3, 48'h20E000);

    start_stream();
    send_tok(TOK_MATCH, 8'h00, 11'd5, 12'd2);
    send_tok(TOK_END, 8'h00, 11'd0, 12'd0);
    finish_stream("m5l2", 3, 48'hC29800);

    start_stream();
    send_tok(TOK_MATCH, 8'h00, 11'd300, 12'd8);
    send_tok(TOK_END, 8'h00, 11'd0, 12'd0);
    finish_stream("m300l8", 4, 48'h89678600);

    start_stream();
    send_tok(TOK_MATCH, 8'h00, 11'd1, 12'd23);
    send_tok(TOK_END, 8'h00, 11'd0, 12'd0);
    finish_stream("m1l23", 4, 48'hC0FF8600);

    start_stream();
    send_tok(TOK_MATCH, 8'h00, 11'd1, 12'd22);
    send_tok(TOK_END, 8'h00, 11'd0, 12'd0);
    finish_stream("m1l22", 4, 48'hC0FF6000);

    // Four literals with the output FIFO full for 20 cycles
    start_stream();
    fo_full = 1'b1;
    fork
      begin
        send_tok(TOK_LIT, 8'h41, 11'd0, 12'd0);
        send_tok(TOK_LIT, 8'h42, 11'd0, 12'd0);
        send_tok(TOK_LIT, 8'h43, 11'd0, 12'd0);
        send_tok(TOK_LIT, 8'h44, 11'd0, 12'd0);
        send_tok(TOK_END, 8'h00, 11'd0, 12'd0);
      end
      begin
        repeat (20) @(negedge clk);
        check("bp_no_output", 32'(got_q.size()), 32'd0);
        check("bp_ready_low", 32'(tok_ready), 32'd0);
        fo_full = 1'b0;
      end
    join
    finish_stream("bp", 6, 48'h2090_8864_4C00);

    // Reset while emitting length-extension nibbles
    start_stream();
    send_tok(TOK_MATCH, 8'h00, 11'd1, 12'd40);
    @(negedge clk);
    check("pre_rst_in_ext", 32'(dut.r_state), 32'(S_EXT));
    rst = 1'b1;
    #1;
    check("mid_rst_out_data",  32'(out_data),  32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_tok_ready", 32'(tok_ready), 32'd0);
    check("mid_rst_all_end",   32'(all_end),   32'd0);
    check("mid_rst_state",     32'(dut.r_state), 32'(S_IDLE));
    ce_encode = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    start_stream();
    send_tok(TOK_LIT, 8'h41, 11'd0, 12'd0);
    send_tok(TOK_END, 8'h00, 11'd0, 12'd0);
    finish_stream("post_rst", 3, 48'h20E000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
